// File: rtl/func_switch_sequencer.sv
// Function-switch sequencer: debounces change_button, waits for vertical blanking,
// blanks the display for a few frames and advances func_index with a one-cycle reset pulse.
module func_switch_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_FUNCS       = 2,
    parameter int BLANK_FRAMES    = 2
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       change_button,
    input  logic       vsync_start,
    output logic [1:0] func_index,
    output logic       func_reset,
    output logic       display_blank,
    output logic       busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int FW = $clog2(BLANK_FRAMES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);
    localparam logic [1:0]    FUNC_LAST  = 2'(NUM_FUNCS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VBL,
        BLANK,
        SWITCH,
        SETTLE
    } state_t;

    logic [1:0]    sync_reg;
    logic [1:0]    prime_reg;
    logic          armed_reg;
    logic          deb_level_reg;
    logic [DW-1:0] deb_cnt_reg;
    logic          press_reg;

    // A press is only armed once a genuine low level has come through the
    // synchroniser after reset, so a button held through reset cannot fire.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_reg      <= '0;
            prime_reg     <= '0;
            armed_reg     <= 1'b0;
            deb_level_reg <= 1'b0;
            deb_cnt_reg   <= '0;
            press_reg     <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], change_button};
            prime_reg <= {prime_reg[0], 1'b1};
            press_reg <= 1'b0;
            if (prime_reg[1] && !sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
            if (sync_reg[1] == deb_level_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                deb_level_reg <= sync_reg[1];
                deb_cnt_reg   <= '0;
                press_reg     <= sync_reg[1] & armed_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DW'(1);
            end
        end
    end

    state_t        state_reg, state_next;
    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [1:0]    func_index_reg, func_index_next;
    logic          func_reset_reg, func_reset_next;
    logic          blank_reg, blank_next;
    logic          busy_reg, busy_next;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_reg      <= IDLE;
            frame_cnt_reg  <= '0;
            func_index_reg <= 2'd0;
            func_reset_reg <= 1'b0;
            blank_reg      <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_cnt_reg  <= frame_cnt_next;
            func_index_reg <= func_index_next;
            func_reset_reg <= func_reset_next;
            blank_reg      <= blank_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_cnt_next  = frame_cnt_reg;
        func_index_next = func_index_reg;
        func_reset_next = 1'b0;
        blank_next      = blank_reg;
        busy_next       = busy_reg;
        case (state_reg)
            IDLE: begin
                if (press_reg) begin
                    state_next = WAIT_VBL;
                    busy_next  = 1'b1;
                end
            end
            WAIT_VBL: begin
                if (vsync_start) begin
                    state_next     = BLANK;
                    blank_next     = 1'b1;
                    frame_cnt_next = '0;
                end
            end
            BLANK: begin
                if (vsync_start) begin
                    frame_cnt_next = frame_cnt_reg + FW'(1);
                    if (frame_cnt_reg == FRAME_LAST) begin
                        state_next      = SWITCH;
                        func_reset_next = 1'b1;
                        func_index_next = (func_index_reg == FUNC_LAST) ? 2'd0
                                                                        : func_index_reg + 2'd1;
                    end
                end
            end
            SWITCH: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                if (vsync_start) begin
                    state_next = IDLE;
                    blank_next = 1'b0;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                blank_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign func_index    = func_index_reg;
    assign func_reset    = func_reset_reg;
    assign display_blank = blank_reg;
    assign busy          = busy_reg;

endmodule
